// File: rtl/sum_uart_tx.sv
// sum_uart_tx: queues 8-bit sum values and sends each one as an async serial
// frame (start, 8 data bits LSB-first, optional even parity, stop) on tx_out.
//
// Build option: define SUM_UART_PARITY_EN to add the even-parity bit
// (11-bit frame). When it is undefined the frame is 10 bits.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (2..255)
//   FIFO_DEPTH    queue entries (power of two, >= 2)
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   in_data       sum value to queue
//   in_valid      push request, sampled every rising edge
//   tx_out        serial line, idle high, registered
//   busy          high while a frame is in progress
//   fifo_full     queue occupancy == FIFO_DEPTH
//   fifo_empty    queue occupancy == 0
//   overflow      sticky, set when a push was dropped
module sum_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       tx_out,
  output logic       busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef SUM_UART_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
  logic [7:0]         shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               busy_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, empty_q;
  logic               ovf_q, ovf_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic               tmr_tc;
  logic               pop;
  logic               push;
  logic               fifo_has_data;

  assign tmr_tc        = (tmr_q == TMR_LAST);
  assign idx_nxt       = idx_q + 3'd1;
  assign fifo_has_data = (count_q != '0);

  // Frame sequencer: tx_d is the line value for the cycle after this edge.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_tc ? '0 : tmr_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        tx_d  = 1'b1;
        if (fifo_has_data) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (tmr_tc) begin
          idx_d   = '0;
          state_d = S_DATA;
          tx_d    = shreg_q[0];
        end
      end

      S_DATA: begin
        if (tmr_tc) begin
          // idx_nxt wraps 7 -> 0, leaving the index ready for the next frame
          idx_d = idx_nxt;
          if (idx_q == 3'd7) begin
`ifdef SUM_UART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^shreg_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shreg_q[idx_nxt];
          end
        end
      end

`ifdef SUM_UART_PARITY_EN
      S_PARITY: begin
        if (tmr_tc) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (tmr_tc) begin
          // Chain straight into the next start bit when data is waiting
          if (fifo_has_data) begin
            pop     = 1'b1;
            shreg_d = mem_q[rd_ptr_q];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Queue bookkeeping: a full queue still accepts when a pop frees a slot.
  always_comb begin
    push     = in_valid && ((count_q != DEPTH_C) || pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = ovf_q | (in_valid & ~push);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; when full, a same-edge write to the popped slot is safe
  // because the pop reads the pre-edge contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      busy_q   <= (state_d != S_IDLE);
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      ovf_q    <= ovf_d;
    end
  end

  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Testbench for sum_uart_tx: stimulus pushes expected bytes into a queue, a
// serial-line monitor decodes every frame from tx_out and compares it.
module tb_sum_uart_tx;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
`ifdef SUM_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       tx_out, busy, fifo_full, fifo_empty, overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         frame_starts[$];

  sum_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .tx_out     (tx_out),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy == 1'b0 && fifo_empty == 1'b1) && n < 3000);
    check(name, int'(busy == 1'b0 && fifo_empty == 1'b1), 1);
  endtask

  // Line monitor: decode each frame mid-bit and check it against the queue.
  initial begin : monitor
    logic [NB-1:0] rx_bits;
    logic [NB-1:0] exp_bits;
    logic [7:0]    eb;
    logic          first;
    int            glitch;
    bit            aborted;
    forever begin
      @(negedge clk);
      if (rst_n && tx_out == 1'b0) begin
        frame_starts.push_back(cyc);
        aborted = 1'b0;
        glitch  = 0;
        rx_bits = '0;
        first   = 1'b0;
        for (int b = 0; b < NB && !aborted; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (c == 0) first = tx_out;
            else if (tx_out != first) glitch++;
            if (c == CPB / 2) rx_bits[b] = tx_out;
          end
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got bits %0h expected no frame", rx_bits);
          end else begin
            eb = exp_q.pop_front();
`ifdef SUM_UART_PARITY_EN
            exp_bits = {1'b1, ^eb, eb, 1'b0};
`else
            exp_bits = {1'b1, eb, 1'b0};
`endif
            check("frame_bits", int'(rx_bits), int'(exp_bits));
            check("bit_stable", glitch, 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int c0;
    logic [7:0] wrap_vals [9];
    wrap_vals = '{8'h00, 8'hFF, 8'h81, 8'h7E, 8'h5A, 8'hC3, 8'h01, 8'h80, 8'h99};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx",    int'(tx_out),     1);
    check("rst_busy",  int'(busy),       0);
    check("rst_empty", int'(fifo_empty), 1);
    check("rst_full",  int'(fifo_full),  0);
    check("rst_ovf",   int'(overflow),   0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 0xA5: latency and busy length
    in_valid = 1'b1; in_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk); in_valid = 1'b0;
    check("lat_e0_tx",    int'(tx_out),     1);
    check("lat_e0_empty", int'(fifo_empty), 0);
    @(negedge clk);
    check("lat_e1_tx",    int'(tx_out),     0);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, FL);
    check("ovf_single", int'(overflow), 0);
    wait_idle("idle_single");

    // Overflow: six consecutive pushes, sixth dropped
    frame_starts.delete();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(i);
      if (i <= 5) exp_q.push_back(8'(i));
      if (i == 6) begin
        check("full_before_6th", int'(fifo_full), 1);
        check("ovf_before_6th",  int'(overflow),  0);
      end
    end
    @(negedge clk); in_valid = 1'b0;
    check("ovf_after_6th", int'(overflow), 1);
    wait_idle("idle_ovf");
    check("ovf_sticky", int'(overflow), 1);
    check("ovf_frames", frame_starts.size(), 5);
    for (int k = 1; k < 5 && k < frame_starts.size(); k++)
      check("b2b_spacing", frame_starts[k] - frame_starts[k-1], FL);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("ovf_cleared", int'(overflow), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Push with pop when full: 0x3C lands on the last STOP cycle
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      exp_q.push_back(8'h10 + 8'(i));
    end
    @(negedge clk); in_valid = 1'b0;
    while (cyc < c0 + 1 + FL) @(negedge clk);
    check("full_pre_pop", int'(fifo_full), 1);
    check("busy_pre_pop", int'(busy),      1);
    in_valid = 1'b1; in_data = 8'h3C; exp_q.push_back(8'h3C);
    @(negedge clk); in_valid = 1'b0;
    check("pp_ovf",   int'(overflow),  0);
    check("pp_full",  int'(fifo_full), 1);
    check("pp_start", int'(tx_out),    0);
    wait_idle("idle_pp");

    // Parity-sensitive bytes (0x07 odd weight, 0x03 even weight)
    in_valid = 1'b1; in_data = 8'h07; exp_q.push_back(8'h07);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
`ifdef SUM_UART_PARITY_EN
    repeat (9 * CPB + CPB / 2) @(negedge clk);
    check("parity_07", int'(tx_out), 1);
`endif
    wait_idle("idle_p07");
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h03; exp_q.push_back(8'h03);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles_03", n, FL);
`ifdef SUM_UART_PARITY_EN
`endif
    wait_idle("idle_p03");

    // Reset in DATA bit 3 with two bytes queued
    @(negedge clk);
    c0 = cyc;
    in_valid = 1'b1; in_data = 8'h07; exp_q.push_back(8'h07);
    @(negedge clk); in_data = 8'h55; exp_q.push_back(8'h55);
    @(negedge clk); in_data = 8'h66; exp_q.push_back(8'h66);
    @(negedge clk); in_valid = 1'b0;
    while (cyc < c0 + 1 + 36) @(negedge clk);
    check("pre_rst_tx",   int'(tx_out), 0);
    check("pre_rst_busy", int'(busy),   1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_tx",    int'(tx_out),     1);
    check("mid_rst_busy",  int'(busy),       0);
    check("mid_rst_empty", int'(fifo_empty), 1);
    check("mid_rst_full",  int'(fifo_full),  0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (!tx_out) n++;
    end
    check("post_rst_low_cycles", n, 0);
    check("post_rst_busy", int'(busy), 0);

    // Wrap-around: nine bytes, one frame apart
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = wrap_vals[i];
      exp_q.push_back(wrap_vals[i]);
      @(negedge clk); in_valid = 1'b0;
      repeat (FL) @(negedge clk);
    end
    wait_idle("idle_wrap");
    repeat (4) @(negedge clk);
    check("exp_drained", exp_q.size(), 0);
    check("final_ovf",   int'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_uart_tx.md
# sum_uart_tx

Downstream consumer for the registered 8-bit nibble-sum output of the microtile adder. Each sum value strobed in by `in_valid` is queued in a small FIFO and shifted out LSB-first as an asynchronous serial frame (start, 8 data, optional parity, stop) on a single pin. This lets off-chip test equipment log every result with one wire. Dropped results are flagged by a sticky overflow bit.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 8: clock cycles per serial bit; legal range 2..255.
- `FIFO_DEPTH`, default 4: queue entries; power of two, ≥2.

Ports:
- `clk`  in  1: single clock; all state on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_data`  in  8: sum value from upstream register.
- `in_valid`  in  1: push request, sampled each rising edge.
- `tx_out`  out  1: serial line, idle high, registered.
- `busy`  out  1: high whenever FSM ≠ IDLE.
- `fifo_full`  out  1: occupancy == `FIFO_DEPTH`.
- `fifo_empty`  out  1: occupancy == 0.
- `overflow`  out  1: sticky; a push was dropped.

## Operation
- **Reset values (asynchronous):** `tx_out`=1, `busy`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0. FIFO pointers and count are zeroed, FSM enters IDLE.
- **Push rule:** a push is accepted when `in_valid`=1 and (count < `FIFO_DEPTH` or a pop occurs in the same cycle). Otherwise the data is discarded and `overflow` is set to 1 until reset.
- **Pop rule:** a pop occurs when the FSM loads a new frame, either from IDLE or at the end of STOP, and only if the FIFO is non-empty. The popped byte goes into the shift register.
- **FSM states:** IDLE → START → DATA → [PARITY] → STOP → (START or IDLE).
  - IDLE: `tx_out`=1. If non-empty: pop, go to START.
  - START: `tx_out`=0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, bit 0 first, each held `CLKS_PER_BIT` cycles. A 3-bit index wraps 7→0 on exit.
  - PARITY (macro only): even parity of the byte, held `CLKS_PER_BIT` cycles.
  - STOP: `tx_out`=1 for `CLKS_PER_BIT` cycles. On the last cycle, if non-empty: pop and go straight to START (no idle gap). Otherwise go to IDLE.
- **Bit timer:** counts 0..`CLKS_PER_BIT`-1 and advances state/bit on terminal count.
- Pushes are accepted in every state; transmission never stalls input.
- **Occupancy:** simultaneous push and pop leaves it unchanged. Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- **Latency:** push sampled at edge E0 into an empty FIFO with FSM idle → `tx_out` falls after edge E1.
- **Frame length:** 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- **Back-to-back frames:** the next start bit follows the stop bit's last cycle directly.
- **Flags:** `fifo_full`/`fifo_empty` are registered and reflect occupancy after each edge. `overflow` rises the edge after the dropped push.
- **Reset mid-frame:** `tx_out` returns high immediately (asynchronously), and queued data is lost.

## Configuration
- `SUM_UART_PARITY_EN`
  - Defined: PARITY state is included; frame is 11 bits; parity bit = XOR of the 8 data bits (even parity).
  - Undefined: no PARITY state or parity logic; frame is 10 bits.

## Test plan
- **Single frame:** `CLKS_PER_BIT`=8, push 0xA5 when idle.
  - `tx_out` low after E1 for 8 cycles.
  - Data bits 1,0,1,0,0,1,0,1, then 8 high cycles.
  - `busy` high for exactly 80 cycles; `overflow`=0.
- **Overflow:** `FIFO_DEPTH`=4, six pushes on consecutive cycles (0x01..0x06) from idle.
  - 0x01..0x05 transmitted back-to-back with no idle gap.
  - 0x06 absent from output; `overflow`=1 from the 6th edge until reset.
- **Push with pop when full:** FIFO full, push 0x3C on the last STOP cycle.
  - Push accepted, `overflow` stays 0, count stays 4.
  - 0x3C appears as the 5th frame.
- **Parity (macro defined):** push 0x07 → parity bit 1. Push 0x03 → parity bit 0. Frame is 88 cycles.
- **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3 with 2 bytes queued.
  - `tx_out`=1 and `busy`=0 without waiting for an edge; `fifo_empty`=1.
  - After release, the line stays idle high with no output.
- **Wrap-around:** push 9 bytes spaced one frame apart.
  - All 9 are received in order, so the pointers wrapped twice with no corruption.
